// File: rtl/csa_pkg.sv
// csa_pkg: shared operation encoding and elaboration helpers for the pipelined
// carry-select adder.
package csa_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_BLOCK_W = 4;

    function automatic int num_blocks(input int width, input int block_w);
        return (block_w < 1) ? 1 : width / block_w;
    endfunction

    // Operand bits still waiting above stage k once that stage has consumed its slice.
    function automatic int skew_width(input int width, input int block_w, input int k);
        return width - (k + 1) * block_w;
    endfunction

endpackage

// File: rtl/carry_select_block.sv
// carry_select_block: one carry-select slice. Both carry candidates ripple in
// parallel and the incoming carry picks the finished one.
module carry_select_block #(
    parameter int BLOCK_W = 4
) (
    input  logic [BLOCK_W-1:0] a,
    input  logic [BLOCK_W-1:0] b,
    input  logic               c_in,
    output logic [BLOCK_W-1:0] sum,
    output logic               c_out,
    output logic               c_msb
);

    logic [BLOCK_W:0]   r0;
    logic [BLOCK_W:0]   r1;
    logic [BLOCK_W-1:0] s0;
    logic [BLOCK_W-1:0] s1;

    always_comb begin
        r0    = '0;
        r1    = '0;
        r1[0] = 1'b1;
        s0    = '0;
        s1    = '0;
        for (int i = 0; i < BLOCK_W; i++) begin
            s0[i]     = a[i] ^ b[i] ^ r0[i];
            r0[i + 1] = (a[i] & b[i]) | (r0[i] & (a[i] ^ b[i]));
            s1[i]     = a[i] ^ b[i] ^ r1[i];
            r1[i + 1] = (a[i] & b[i]) | (r1[i] & (a[i] ^ b[i]));
        end
    end

    // c_msb is the carry into the slice MSB; xor with c_out gives signed overflow.
    assign sum   = c_in ? s1 : s0;
    assign c_out = c_in ? r1[BLOCK_W] : r0[BLOCK_W];
    assign c_msb = c_in ? r1[BLOCK_W-1] : r0[BLOCK_W-1];

endmodule

// File: rtl/pipelined_carry_select_adder.sv
// pipelined_carry_select_adder: add/sub with one carry-select block per pipeline
// stage, skewed operand registers and a valid/ready stream interface.
module pipelined_carry_select_adder
    import csa_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int BLOCK_W = DEF_BLOCK_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf
);

    localparam int NB = num_blocks(WIDTH, BLOCK_W);

    if (BLOCK_W < 1 || WIDTH % BLOCK_W != 0) begin : g_bad_params
        $error("WIDTH must be a positive multiple of BLOCK_W");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    // The whole pipe moves as one; a stalled output freezes every stage.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign b_eff    = (op_e'(op) == OP_SUB) ? ~b : b;
    assign c_eff    = (op_e'(op) == OP_SUB) ? !c_in : c_in;

    for (genvar k = 0; k < NB; k++) begin : g_stage
        localparam int LO  = k * BLOCK_W;
        localparam int SKW = skew_width(WIDTH, BLOCK_W, k);
        logic [BLOCK_W-1:0]    a_blk;
        logic [BLOCK_W-1:0]    b_blk;
        logic [BLOCK_W-1:0]    sum_blk;
        logic [LO+BLOCK_W-1:0] sum_d;
        logic [LO+BLOCK_W-1:0] sum_q;
        logic                  cin_blk;
        logic                  vld_in;
        logic                  cout_blk;
        logic                  vld_q;
        logic                  c_q;
        logic                  load;

        if (k == 0) begin : g_src
            assign a_blk   = a[BLOCK_W-1:0];
            assign b_blk   = b_eff[BLOCK_W-1:0];
            assign cin_blk = c_eff;
            assign vld_in  = in_valid;
            assign sum_d   = sum_blk;
        end else begin : g_src
            assign a_blk   = g_stage[k-1].g_skew.a_q[BLOCK_W-1:0];
            assign b_blk   = g_stage[k-1].g_skew.b_q[BLOCK_W-1:0];
            assign cin_blk = g_stage[k-1].c_q;
            assign vld_in  = g_stage[k-1].vld_q;
            assign sum_d   = {sum_blk, g_stage[k-1].sum_q};
        end

        assign load = adv && vld_in;

        if (k == NB - 1) begin : g_top
            logic c_msb;
            logic ovf_q;
            carry_select_block #(.BLOCK_W(BLOCK_W)) u_blk (
                .a     (a_blk),
                .b     (b_blk),
                .c_in  (cin_blk),
                .sum   (sum_blk),
                .c_out (cout_blk),
                .c_msb (c_msb)
            );
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) ovf_q <= 1'b0;
                else if (load) ovf_q <= cout_blk ^ c_msb;
            end
        end else begin : g_mid
            carry_select_block #(.BLOCK_W(BLOCK_W)) u_blk (
                .a     (a_blk),
                .b     (b_blk),
                .c_in  (cin_blk),
                .sum   (sum_blk),
                .c_out (cout_blk),
                .c_msb ()
            );
        end

        // Upper operand slices ride along until their own stage consumes them.
        if (SKW > 0) begin : g_skew
            logic [SKW-1:0] a_d;
            logic [SKW-1:0] b_d;
            logic [SKW-1:0] a_q;
            logic [SKW-1:0] b_q;
            if (k == 0) begin : g_in
                assign a_d = a[WIDTH-1:BLOCK_W];
                assign b_d = b_eff[WIDTH-1:BLOCK_W];
            end else begin : g_in
                assign a_d = g_stage[k-1].g_skew.a_q[SKW+BLOCK_W-1:BLOCK_W];
                assign b_d = g_stage[k-1].g_skew.b_q[SKW+BLOCK_W-1:BLOCK_W];
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (load) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                c_q   <= 1'b0;
                sum_q <= '0;
            end else begin
                if (adv) vld_q <= vld_in;
                if (load) begin
                    c_q   <= cout_blk;
                    sum_q <= sum_d;
                end
            end
        end
    end

    assign out_valid = g_stage[NB-1].vld_q;
    assign s         = g_stage[NB-1].sum_q;
    assign c_out     = g_stage[NB-1].c_q;
    assign ovf       = g_stage[NB-1].g_top.ovf_q;

endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
// tb_pipelined_carry_select_adder: scoreboard bench for the 16-bit/4-stage adder
// plus a single-stage 8-bit instance.
module tb_pipelined_carry_select_adder;
    import csa_pkg::*;

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        o;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, op, c_in, out_valid, out_ready, c_out, ovf;
    logic [15:0] a, b, s;
    logic        w8_in_valid, w8_in_ready, w8_op, w8_c_in, w8_out_valid, w8_out_ready, w8_c_out, w8_ovf;
    logic [7:0]  w8_a, w8_b, w8_s;

    int   checks = 0;
    int   errors = 0;
    int   popped = 0;
    exp_t q[$];
    exp_t got_e;

    always #5 clk = ~clk;

    pipelined_carry_select_adder #(.WIDTH(16), .BLOCK_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .c_out(c_out), .ovf(ovf)
    );

    pipelined_carry_select_adder #(.WIDTH(8), .BLOCK_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(w8_in_valid), .in_ready(w8_in_ready), .op(w8_op),
        .a(w8_a), .b(w8_b), .c_in(w8_c_in), .out_valid(w8_out_valid), .out_ready(w8_out_ready),
        .s(w8_s), .c_out(w8_c_out), .ovf(w8_ovf)
    );

    function automatic exp_t model(input logic o, input logic [15:0] x, input logic [15:0] y, input logic ci);
        logic [15:0] be;
        logic [16:0] r;
        exp_t        e;
        be  = o ? ~y : y;
        r   = {1'b0, x} + {1'b0, be} + {16'd0, (o ? !ci : ci)};
        e.s = r[15:0];
        e.c = r[16];
        e.o = (x[15] == be[15]) && (r[15] != x[15]);
        return e;
    endfunction

    // Output scoreboard: a beat leaves on the next edge when valid and ready are both high.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat got s=%h c=%b o=%b required none", s, c_out, ovf);
            end else begin
                got_e = q.pop_front();
                popped++;
                if ({s, c_out, ovf} !== got_e) begin
                    errors++;
                    $display("FAIL result got s=%h c=%b o=%b required s=%h c=%b o=%b",
                             s, c_out, ovf, got_e.s, got_e.c, got_e.o);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic send(input logic o, input logic [15:0] x, input logic [15:0] y, input logic ci, input exp_t e);
        logic ok = 1'b0;
        op = o; a = x; b = y; c_in = ci; in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back(e);
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_accept got in_ready=0 required 1 within 50 cycles");
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain got pending=%0d required 0", name, q.size());
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({out_valid, s, c_out, ovf} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b s=%h c=%b o=%b required all 0", out_valid, s, c_out, ovf);
        end
        checks++;
        if ({w8_out_valid, w8_s, w8_c_out, w8_ovf} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs_w8 got v=%b s=%h required all 0", w8_out_valid, w8_s);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b required 1", in_ready);
        end
    endtask

    task automatic test_latency();
        send(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, {16'h0000, 1'b1, 1'b0});
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL latency_early edge+%0d got out_valid=%b required 0", i, out_valid);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency got out_valid=%b required 1 after 4 edges", out_valid);
        end
        drain("latency");
    endtask

    task automatic test_add();
        send(OP_ADD, 16'h7FFF, 16'h0001, 1'b0, {16'h8000, 1'b0, 1'b1});
        send(OP_ADD, 16'h1234, 16'h0FCD, 1'b1, {16'h2202, 1'b0, 1'b0});
        send(OP_ADD, 16'h8000, 16'h8000, 1'b0, {16'h0000, 1'b1, 1'b1});
        drain("add");
    endtask

    task automatic test_sub();
        send(OP_SUB, 16'h0003, 16'h0005, 1'b0, {16'hFFFE, 1'b0, 1'b0});
        send(OP_SUB, 16'h8000, 16'h0001, 1'b1, {16'h7FFE, 1'b1, 1'b1});
        send(OP_SUB, 16'h0005, 16'h0003, 1'b0, {16'h0002, 1'b1, 1'b0});
        drain("sub");
    endtask

    task automatic test_back_to_back();
        logic [15:0] xa [6];
        logic [15:0] xb [6];
        logic        xo [6];
        logic        xc [6];
        logic [17:0] held = '0;
        logic        held_v = 1'b0;
        int          sent = 0;
        int          start = popped;
        for (int i = 0; i < 6; i++) begin
            xa[i] = 16'($urandom);
            xb[i] = 16'($urandom);
            xo[i] = 1'($urandom);
            xc[i] = 1'($urandom);
        end
        for (int cyc = 0; cyc < 60 && (sent < 6 || q.size() != 0); cyc++) begin
            out_ready = !(cyc >= 5 && cyc < 8);
            in_valid  = (sent < 6);
            if (sent < 6) begin
                op = xo[sent]; a = xa[sent]; b = xb[sent]; c_in = xc[sent];
            end
            @(negedge clk);
            if (held_v) begin
                checks++;
                if ({s, c_out, ovf} !== held) begin
                    errors++;
                    $display("FAIL stall_hold got %h required %h", {s, c_out, ovf}, held);
                end
            end
            if (out_valid && !out_ready) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_in_ready got %b required 0", in_ready);
                end
            end
            held_v = out_valid && !out_ready;
            held   = {s, c_out, ovf};
            if (in_valid && in_ready) begin
                q.push_back(model(xo[sent], xa[sent], xb[sent], xc[sent]));
                sent++;
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (popped - start != 6 || q.size() != 0) begin
            errors++;
            $display("FAIL stream_count got delivered=%0d pending=%0d required 6 and 0", popped - start, q.size());
        end
    endtask

    task automatic test_reset_midflight();
        logic seen = 1'b0;
        out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            op = OP_ADD; a = 16'(j + 1); b = 16'h0100; c_in = 1'b0; in_valid = 1'b1;
            @(negedge clk);
            checks++;
            if (!in_ready) begin
                errors++;
                $display("FAIL midflight_accept got in_ready=0 required 1");
            end else begin
                q.push_back(model(OP_ADD, 16'(j + 1), 16'h0100, 1'b0));
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midflight_front got out_valid=%b required 1", out_valid);
        end
        #1 rst_n = 1'b0;
        q.delete();
        #1;
        checks++;
        if ({out_valid, s} !== 17'd0) begin
            errors++;
            $display("FAIL async_reset got v=%b s=%h required 0 0", out_valid, s);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL flushed_beat got out_valid=1 required 0 after reset");
        end
    endtask

    task automatic test_narrow_w8();
        @(posedge clk); #1;
        w8_op = OP_ADD; w8_a = 8'hF0; w8_b = 8'h0F; w8_c_in = 1'b1; w8_in_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (w8_in_ready !== 1'b1 || w8_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL w8_pre got rdy=%b v=%b required 1 0", w8_in_ready, w8_out_valid);
        end
        @(posedge clk); #1;
        w8_in_valid = 1'b0;
        checks++;
        if (w8_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL w8_latency got out_valid=%b required 1", w8_out_valid);
        end
        checks++;
        if ({w8_s, w8_c_out, w8_ovf} !== {8'h00, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL w8_result got s=%h c=%b o=%b required s=00 c=1 o=0", w8_s, w8_c_out, w8_ovf);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; op = 1'b0; a = '0; b = '0; c_in = 1'b0; out_ready = 1'b1;
        w8_in_valid = 1'b0; w8_op = 1'b0; w8_a = '0; w8_b = '0; w8_c_in = 1'b0; w8_out_ready = 1'b1;
        test_reset();
        test_latency();
        test_add();
        test_sub();
        test_back_to_back();
        test_reset_midflight();
        test_narrow_w8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
